// File: rtl/alu_op_sequencer_pkg.sv
// Shared widths, ALU opcodes, flag bit positions and sequencer state encoding.
// Imported by the sequencer and by the ALU it drives.
package alu_op_sequencer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  // Flag vector is {Zero, CarryOut, Overflow}.
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      ALUOP_AND, ALUOP_OR, ALUOP_ADD, ALUOP_SUB, ALUOP_SLT: is_legal_op = 1'b1;
      default:                                            is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT with {Zero, CarryOut, Overflow} flags.
// Latency: zero cycles (purely combinational).
// Backpressure: none; result follows operands.
module alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] result,
  output logic [2:0]            flag
);
  import alu_op_sequencer_pkg::*;

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;
  logic                carry;
  logic                ovf;
  logic                slt;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign slt  = $signed(a) < $signed(b);

  // For SUB the carry flag reports a borrow (a < b unsigned).
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      ALUOP_AND: result = a & b;
      ALUOP_OR:  result = a | b;
      ALUOP_ADD: begin
        result = sum[DATA_WIDTH-1:0];
        carry  = sum[DATA_WIDTH];
        ovf    = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      ALUOP_SUB: begin
        result = diff[DATA_WIDTH-1:0];
        carry  = diff[DATA_WIDTH];
        ovf    = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (diff[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      ALUOP_SLT: result = {{(DATA_WIDTH-1){1'b0}}, slt};
      default:   result = '0;
    endcase
  end

  always_comb begin
    flag             = '0;
    flag[FLAG_ZERO]  = (result == '0);
    flag[FLAG_CARRY] = carry;
    flag[FLAG_OVF]   = ovf;
  end

endmodule

// File: rtl/regfile.sv
// Register file with two combinational read ports and one synchronous write port; r0 reads as zero.
// Latency: reads zero cycles, writes visible after the clock edge.
// Backpressure: none.
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);
  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wen && (waddr != '0)) mem_q[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one register-to-register ALU command at a time: read operands, execute, write back, respond.
// Latency: accept at edge N, rf_wen during cycle N+3, rsp_valid from cycle N+4; issue interval 5 cycles.
// Backpressure: response held stable until rsp_ready; cmd_ready is low whenever not idle or in reset.
module alu_op_sequencer #(
  parameter int DATA_WIDTH = alu_op_sequencer_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = alu_op_sequencer_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] cmd_rs2,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_wen,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [2:0]            alu_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic [2:0]            rsp_flag,
  output logic                  rsp_err,
  output logic [31:0]           op_count
);
  import alu_op_sequencer_pkg::*;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [2:0]            flag_q, flag_d;
  logic                  err_q, err_d;
  logic [31:0]           count_q, count_d;
  logic                  legal;

  assign legal = is_legal_op(op_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    flag_d   = flag_q;
    err_d    = err_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          rs1_d   = cmd_rs1;
          rs2_d   = cmd_rs2;
          rd_d    = cmd_rd;
          state_d = S_READ;
        end
      end
      S_READ: begin
        opa_d   = rf_rdata1;
        opb_d   = rf_rdata2;
        state_d = S_EXEC;
      end
      // Illegal opcodes never leak ALU output: result and flags are zeroed.
      S_EXEC: begin
        err_d    = !legal;
        result_d = legal ? alu_result : '0;
        flag_d   = legal ? alu_flag : 3'b000;
        state_d  = S_WB;
      end
      S_WB: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          count_d = count_q + 32'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      flag_q   <= '0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // Ready is gated by rst so nothing is accepted while reset is held.
  assign cmd_ready  = rst && (state_q == S_IDLE);
  assign rf_raddr1  = rs1_q;
  assign rf_raddr2  = rs2_q;
  assign alu_a      = opa_q;
  assign alu_b      = opb_q;
  assign alu_op     = op_q;
  assign rf_waddr   = rd_q;
  assign rf_wdata   = result_q;
  assign rf_wen     = (state_q == S_WB) && (rd_q != '0) && !err_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = result_q;
  assign rsp_flag   = flag_q;
  assign rsp_err    = err_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer wired to the ALU and register file.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [DW-1:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic          rf_wen;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [2:0]    alu_op, alu_flag;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_result;
  logic [2:0]    rsp_flag;
  logic [31:0]   op_count;

  logic          tb_we;
  logic [AW-1:0] tb_waddr;
  logic [DW-1:0] tb_wdata;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  alu #(.DATA_WIDTH(DW)) u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result), .flag(alu_flag)
  );

  regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_rf (
    .clk(clk),
    .wen(tb_we | rf_wen),
    .waddr(tb_we ? tb_waddr : rf_waddr),
    .wdata(tb_we ? tb_wdata : rf_wdata),
    .raddr1(rf_raddr1), .raddr2(rf_raddr2),
    .rdata1(rf_rdata1), .rdata2(rf_rdata2)
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [2:0]  flag;
    logic        err;
    logic        wen;
    int          stall;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          wen_pulses = 0;
  int          exp_pulses = 0;
  logic [31:0] exp_count = 0;
  logic [31:0] model_rf [0:31];
  vec_t        vecs [10];

  always @(posedge clk) if (rf_wen === 1'b1) wen_pulses <= wen_pulses + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
    model_rf[a] = d;
  endtask

  task automatic run_cmd(input vec_t v);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_rs1 = v.rs1; cmd_rs2 = v.rs2; cmd_rd = v.rd;
    rsp_ready = (v.stall == 0);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);                      // READ
    cmd_valid = 1'b0;
    chk("read_raddr1", 32'(rf_raddr1), 32'(v.rs1));
    chk("read_raddr2", 32'(rf_raddr2), 32'(v.rs2));
    chk("read_busy_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);                      // EXEC
    chk("exec_alu_a", alu_a, model_rf[v.rs1]);
    chk("exec_alu_b", alu_b, model_rf[v.rs2]);
    chk("exec_alu_op", 32'(alu_op), 32'(v.op));
    chk("exec_wen", 32'(rf_wen), 32'd0);
    @(negedge clk);                      // WB
    chk("wb_wen", 32'(rf_wen), 32'(v.wen));
    if (v.wen) begin
      chk("wb_waddr", 32'(rf_waddr), 32'(v.rd));
      chk("wb_wdata", rf_wdata, v.res);
    end
    @(negedge clk);                      // RESP
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_result", rsp_result, v.res);
    chk("rsp_flag", 32'(rsp_flag), 32'(v.flag));
    chk("rsp_err", 32'(rsp_err), 32'(v.err));
    chk("rsp_wen_low", 32'(rf_wen), 32'd0);
    // Stalled response: a new command is offered and must be ignored.
    for (int s = 0; s < v.stall; s++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", rsp_result, v.res);
      chk("stall_flag", 32'(rsp_flag), 32'(v.flag));
      chk("stall_ready", 32'(cmd_ready), 32'd0);
      chk("stall_count", op_count, exp_count);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);                      // back in IDLE
    exp_count = exp_count + 32'd1;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_op_count", op_count, exp_count);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    if (v.wen) begin
      model_rf[v.rd] = v.res;
      exp_pulses++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{ALUOP_ADD, 5'd1, 5'd2, 5'd3,  32'd12,         3'b000, 1'b0, 1'b1, 0};
    vecs[1] = '{ALUOP_SUB, 5'd1, 5'd2, 5'd4,  32'hFFFF_FFFE,  3'b010, 1'b0, 1'b1, 0};
    vecs[2] = '{ALUOP_SLT, 5'd1, 5'd2, 5'd5,  32'd1,          3'b000, 1'b0, 1'b1, 0};
    vecs[3] = '{ALUOP_ADD, 5'd1, 5'd2, 5'd0,  32'd12,         3'b000, 1'b0, 1'b0, 0};
    vecs[4] = '{3'b011,    5'd1, 5'd2, 5'd6,  32'd0,          3'b000, 1'b1, 1'b0, 0};
    vecs[5] = '{ALUOP_AND, 5'd1, 5'd1, 5'd7,  32'd5,          3'b000, 1'b0, 1'b1, 0};
    vecs[6] = '{ALUOP_OR,  5'd1, 5'd2, 5'd8,  32'd7,          3'b000, 1'b0, 1'b1, 0};
    vecs[7] = '{ALUOP_ADD, 5'd3, 5'd4, 5'd9,  32'h0000_000A,  3'b010, 1'b0, 1'b1, 0};
    vecs[8] = '{ALUOP_SUB, 5'd1, 5'd1, 5'd10, 32'd0,          3'b100, 1'b0, 1'b1, 0};
    vecs[9] = '{ALUOP_ADD, 5'd1, 5'd2, 5'd14, 32'd12,         3'b000, 1'b0, 1'b1, 5};

    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    rsp_ready = 1'b1; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;

    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_op_count", op_count, 32'd0);
    chk("reset_wen", 32'(rf_wen), 32'd0);
    rst = 1'b1;
    #1 chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);

    for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

    // Reset asserted while a command is in EXEC.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ALUOP_ADD; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_rd = 5'd12;
    @(negedge clk);                      // READ
    cmd_valid = 1'b0;
    @(negedge clk);                      // EXEC
    chk("mid_exec_alu_a", alu_a, 32'd5);
    rst = 1'b0;
    #1;
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_op_count", op_count, 32'd0);
    chk("midrst_wen", 32'(rf_wen), 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_no_write", 32'(wen_pulses), 32'(exp_pulses));
    rst = 1'b1;
    exp_count = 32'd0;
    #1 chk("midrst_release_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("midrst_still_no_write", 32'(wen_pulses), 32'(exp_pulses));

    run_cmd('{ALUOP_ADD, 5'd1, 5'd2, 5'd11, 32'd12, 3'b000, 1'b0, 1'b1, 0});
    @(negedge clk);
    chk("total_wen_pulses", 32'(wen_pulses), 32'(exp_pulses));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side initiator for the ALU and the 2-read/1-write register file.
- Accepts one register-to-register ALU command per valid/ready handshake and drives the register-file read ports.
- Feeds the ALU from registered operands, writes the result back, and returns result and flags on a response handshake.
- Sits between an instruction source (test driver or future decode stage) and the alu/regfile datapath.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- ADDR_WIDTH, 5, register address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  ALU opcode.
- cmd_rs1  in  ADDR_WIDTH  source register A.
- cmd_rs2  in  ADDR_WIDTH  source register B.
- cmd_rd  in  ADDR_WIDTH  destination register.
- rf_raddr1  out  ADDR_WIDTH  register-file read address 1.
- rf_raddr2  out  ADDR_WIDTH  register-file read address 2.
- rf_rdata1  in  DATA_WIDTH  combinational read data 1.
- rf_rdata2  in  DATA_WIDTH  combinational read data 2.
- rf_waddr  out  ADDR_WIDTH  write address.
- rf_wdata  out  DATA_WIDTH  write data.
- rf_wen  out  1  write enable, one cycle.
- alu_a  out  DATA_WIDTH  ALU operand A.
- alu_b  out  DATA_WIDTH  ALU operand B.
- alu_op  out  3  ALU opcode.
- alu_result  in  DATA_WIDTH  combinational ALU result.
- alu_flag  in  3  {Zero, CarryOut, Overflow}.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  DATA_WIDTH  captured result.
- rsp_flag  out  3  captured flags.
- rsp_err  out  1  illegal opcode.
- op_count  out  32  count of completed commands.

Behaviour:
- Legal opcodes: AND 000, OR 001, ADD 010, SUB 110, SLT 111. All others are illegal.
- States: IDLE -> READ -> EXEC -> WB -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1 (forced to 0 while rst is low).
  - On cmd_valid&&cmd_ready, latch op/rs1/rs2/rd and go to READ.
- READ (1 cycle):
  - rf_raddr1=rs1, rf_raddr2=rs2.
  - Capture rf_rdata1/2 into the operand registers at the clock edge.
- EXEC (1 cycle):
  - alu_a/alu_b/alu_op driven from registers.
  - Capture alu_result and alu_flag at the clock edge.
  - Illegal op: result forced to 0, flags 000, err set.
- WB (1 cycle):
  - rf_wen=1, rf_waddr=rd, rf_wdata=captured result.
  - Write is suppressed (rf_wen=0) when rd==0 or err=1.
- RESP:
  - rsp_valid=1 with result/flag/err held stable until rsp_ready.
  - On the handshake, op_count increments (wraps at 2^32-1 -> 0) and the state returns to IDLE.
- Latency: command accept at edge N; rf_wen high during cycle N+3; rsp_valid first high in cycle N+4. Minimum issue interval is 5 cycles.
- rsp_ready may be high early; it has effect only in RESP.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- No hazard logic is needed: a new command reads only after the previous write-back.
- Reset (rst low, any time, including mid-operation):
  - State -> IDLE; all outputs 0, including cmd_ready, rf_wen, rsp_valid, and op_count.
  - Any in-flight write is cancelled.
  - First acceptance is possible on the first edge after rst goes high.

Decomposition:
- Shared package/include: DATA_WIDTH, ADDR_WIDTH, the ALUOP_* opcode constants, flag bit indices (ZERO=2, CARRY=1, OVF=0), and the state encoding.
- The sequencer is a single module.
- The bench instantiates the existing alu and register file and connects them to the rf_* and alu_* ports.

Test Plan:
- Preload r1=5, r2=7; issue ADD rs1=1 rs2=2 rd=3 -> rf_wen one cycle at N+3 with waddr=3 and wdata=12; response result=12, flag=000, err=0; op_count=1.
- SUB rs1=1 rs2=2 rd=4 -> wdata=0xFFFFFFFE, flag=010 (borrow). Then SLT rs1=1 rs2=2 rd=5 -> result=1.
- ADD rd=0 with r1=5, r2=7 -> rf_wen stays 0 throughout; response result=12.
- Illegal op 011 -> rsp_err=1, result=0, flag=000, no write. AND r1,r1 (5&5) then yields result=5, err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and its data stay stable; cmd_ready stays 0; op_count increments only on the handshake cycle.
- Pull rst low during EXEC -> rf_wen never asserts, rsp_valid=0, op_count=0. After release, cmd_ready=1 and a new ADD completes normally.
